// File: rtl/servant_gpio_irq.sv
// servant_gpio_irq: Wishbone GPIO with set/clear/toggle outputs and edge-detect input interrupts
module servant_gpio_irq #(
    parameter int NUM_GPIO = 8,
    parameter logic [NUM_GPIO-1:0] RESET_OUT = '0
) (
    input  logic                i_wb_clk,
    input  logic                i_wb_rst,
    input  logic [2:0]          i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    input  logic [NUM_GPIO-1:0] i_gpio,
    output logic [NUM_GPIO-1:0] o_gpio,
    output logic                o_irq
);
    localparam int N = NUM_GPIO;
    logic [N-1:0] out_r, out_nxt, en, pol, pend, s1, s2, s3, be, mask, evt;
    logic [31:0] be32, mask32, rd;
    logic acc, wr, unused_hi;
    assign be32 = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign mask32 = i_wb_dat & be32;
    assign be = be32[N-1:0];
    assign mask = mask32[N-1:0];
    // Pins at NUM_GPIO and above have no storage, so their write data is dropped
    assign unused_hi = ^{mask32, be32};
    assign acc = i_wb_cyc & ~o_wb_ack;
    assign wr = acc & i_wb_we;
    assign evt = (pol & s2 & ~s3) | (~pol & ~s2 & s3);
    assign o_gpio = out_r;
    assign o_irq = |(pend & en);
    always_comb begin
        rd = i_wb_adr == 3'd4 ? 32'(s2) :
             i_wb_adr == 3'd5 ? 32'(en) :
             i_wb_adr == 3'd6 ? 32'(pol) :
             i_wb_adr == 3'd7 ? 32'(pend) : 32'(out_r);
        out_nxt = i_wb_adr[1:0] == 2'd0 ? ((out_r & ~be) | mask) :
                  i_wb_adr[1:0] == 2'd1 ? (out_r | mask) :
                  i_wb_adr[1:0] == 2'd2 ? (out_r & ~mask) : (out_r ^ mask);
    end
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            out_r <= RESET_OUT;
            en <= '0;
            pol <= '0;
            pend <= '0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            s1 <= i_gpio;
            s2 <= s1;
            s3 <= s2;
            o_wb_ack <= acc;
            if (acc) o_wb_rdt <= rd;
            if (wr && !i_wb_adr[2]) out_r <= out_nxt;
            if (wr && i_wb_adr == 3'd5) en <= (en & ~be) | mask;
            if (wr && i_wb_adr == 3'd6) pol <= (pol & ~be) | mask;
            // A new event sets the flag even when the same bit is being cleared
            pend <= (pend & ~((wr && i_wb_adr == 3'd7) ? mask : '0)) | (evt & en);
        end
    end
endmodule

// File: tb/tb_servant_gpio_irq.sv
// tb_servant_gpio_irq: scoreboard bench; bus ops queue expected read data or o_gpio, a monitor checks on each ack
module tb_servant_gpio_irq;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] adr = '0;
    logic [31:0] dat = '0, rdt;
    logic [3:0] sel = '0;
    logic we = 1'b0, cyc = 1'b0, ack, irq;
    logic [7:0] gpio_i = '0, gpio_o;
    int n_cmp = 0, n_fail = 0;
    typedef struct {
        logic kind;
        logic [31:0] exp;
        string name;
    } item_t;
    item_t q[$];

    servant_gpio_irq #(.NUM_GPIO(8), .RESET_OUT(8'hA5)) dut (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat),
        .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt),
        .o_wb_ack(ack), .i_gpio(gpio_i), .o_gpio(gpio_o), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // kind 0 compares read data, kind 1 compares o_gpio after the ack edge
    task automatic bus(input string nm, input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic k, input logic [31:0] e);
        bit got = 0;
        q.push_back('{k, e, nm});
        @(negedge clk);
        cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1 got = ack;
        end
        cyc = 1'b0; we = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack within 4 cycles", nm);
            q.delete(q.size() - 1);
        end else begin
            @(posedge clk);
            #1 chk({nm, "_ack_pulse"}, 32'(ack), 32'd0);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (ack) begin
                if (q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_ack: got ack expected none");
                end else begin
                    it = q.pop_front();
                    chk(it.name, it.kind ? 32'(gpio_o) : rdt, it.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(3);
        chk("rst_gpio", 32'(gpio_o), 32'hA5);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdt", rdt, 32'd0);
        @(negedge clk) rst = 1'b0;
        bus("rd_out", 0, 3'd0, 0, 4'hF, 0, 32'hA5);
        for (int r = 4; r < 8; r++) bus($sformatf("rd_reg%0d", r), 0, 3'(r), 0, 4'hF, 0, 32'h0);
        bus("wr_out", 1, 3'd0, 32'h0F, 4'hF, 1, 32'h0F);
        bus("wr_set", 1, 3'd1, 32'hF0, 4'hF, 1, 32'hFF);
        bus("wr_clr", 1, 3'd2, 32'h03, 4'hF, 1, 32'hFC);
        bus("wr_tgl", 1, 3'd3, 32'h81, 4'hF, 1, 32'h7D);
        bus("rd_tgl", 0, 3'd3, 0, 4'hF, 0, 32'h7D);
        bus("sel_none", 1, 3'd0, 32'h0, 4'h0, 1, 32'h7D);
        bus("sel_upper", 1, 3'd0, 32'h0, 4'hE, 1, 32'h7D);
        bus("wr_in_ignored", 1, 3'd4, 32'hFF, 4'hF, 1, 32'h7D);
        bus("wr_pol_wide", 1, 3'd6, 32'hFFFF_FFFF, 4'hF, 1, 32'h7D);
        bus("rd_pol_wide", 0, 3'd6, 0, 4'hF, 0, 32'hFF);
        bus("wr_en", 1, 3'd5, 32'h01, 4'hF, 1, 32'h7D);
        bus("wr_pol", 1, 3'd6, 32'h01, 4'hF, 1, 32'h7D);
        @(negedge clk) gpio_i[0] = 1'b1;
        wait_cyc(1);
        chk("lat_k_irq", 32'(irq), 32'd0);
        wait_cyc(1);
        chk("lat_k1_irq", 32'(irq), 32'd0);
        wait_cyc(1);
        chk("lat_k2_irq", 32'(irq), 32'd1);
        bus("rd_in", 0, 3'd4, 0, 4'hF, 0, 32'h01);
        bus("rd_pend_rise", 0, 3'd7, 0, 4'hF, 0, 32'h01);
        bus("w1c_pend", 1, 3'd7, 32'h01, 4'hF, 1, 32'h7D);
        chk("w1c_irq", 32'(irq), 32'd0);
        @(negedge clk) gpio_i[7] = 1'b1;
        wait_cyc(4);
        bus("wr_en80", 1, 3'd5, 32'h80, 4'hF, 1, 32'h7D);
        bus("wr_pol0", 1, 3'd6, 32'h00, 4'hF, 1, 32'h7D);
        @(negedge clk) gpio_i[7] = 1'b0;
        wait_cyc(4);
        bus("rd_pend_fall", 0, 3'd7, 0, 4'hF, 0, 32'h80);
        chk("fall_irq", 32'(irq), 32'd1);
        @(negedge clk) gpio_i[7:6] = 2'b11;
        wait_cyc(4);
        @(negedge clk) gpio_i[6] = 1'b0;
        wait_cyc(4);
        bus("rd_pend_masked", 0, 3'd7, 0, 4'hF, 0, 32'h80);
        bus("wr_en01", 1, 3'd5, 32'h01, 4'hF, 1, 32'h7D);
        bus("wr_pol01", 1, 3'd6, 32'h01, 4'hF, 1, 32'h7D);
        bus("w1c_pend80", 1, 3'd7, 32'h80, 4'hF, 1, 32'h7D);
        @(negedge clk) gpio_i[0] = 1'b0;
        wait_cyc(4);
        @(negedge clk) gpio_i[0] = 1'b1;
        wait_cyc(4);
        bus("rd_pend_pre", 0, 3'd7, 0, 4'hF, 0, 32'h01);
        @(negedge clk) gpio_i[0] = 1'b0;
        wait_cyc(4);
        @(negedge clk) gpio_i[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        bus("w1c_collide", 1, 3'd7, 32'h01, 4'hF, 1, 32'h7D);
        chk("collide_irq", 32'(irq), 32'd1);
        bus("rd_pend_collide", 0, 3'd7, 0, 4'hF, 0, 32'h01);
        q.push_back('{1'b0, 32'h7D, "held_rd0"});
        q.push_back('{1'b0, 32'h7D, "held_rd1"});
        @(negedge clk);
        cyc = 1'b1; we = 1'b0; adr = 3'd0; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(1);
            chk($sformatf("held_ack%0d", i), 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        cyc = 1'b0;
        q.push_back('{1'b1, 32'h00, "rst_wr_commit"});
        @(negedge clk);
        cyc = 1'b1; we = 1'b1; adr = 3'd0; dat = 32'h0; sel = 4'hF;
        wait_cyc(1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_gpio", 32'(gpio_o), 32'hA5);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_rdt", rdt, 32'd0);
        wait_cyc(1);
        chk("mid_rst_ack_hold", 32'(ack), 32'd0);
        cyc = 1'b0; we = 1'b0;
        @(negedge clk) rst = 1'b0;
        wait_cyc(3);
        bus("post_rd_out", 0, 3'd0, 0, 4'hF, 0, 32'hA5);
        bus("post_rd_in", 0, 3'd4, 0, 4'hF, 0, 32'h81);
        bus("post_rd_en", 0, 3'd5, 0, 4'hF, 0, 32'h0);
        bus("post_rd_pol", 0, 3'd6, 0, 4'hF, 0, 32'h0);
        bus("post_rd_pend", 0, 3'd7, 0, 4'hF, 0, 32'h0);
        chk("post_irq", 32'(irq), 32'd0);
        wait_cyc(3);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
